seven_seg_scanner: RTL and testbench

- Time-multiplexed scan controller for a 4-digit 7-segment display.
- Shares one `binary_to_7s`-style nibble decoder across all four digits: presents one nibble per slot, registers the returned pattern and drives active-low segment and anode pins.
- Adds inter-digit blanking against ghosting and double-buffers the displayed value so updates apply only at frame boundaries (no tearing).
- Sits between the datapath producing a 16-bit value and the board's display pins.

---
 rtl/seven_seg_scanner_if.sv | 24 ++
 rtl/seven_seg_scanner.sv | 133 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Signal bundle between the value producer / decoder side and the 7-segment scanner.
// The master side owns the value, strobes and decoder pattern; the slave side is the scanner.
interface seven_seg_scanner_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        load;
  logic [3:0]  dec_num;
  logic [7:0]  dec_ss;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        pending;
  logic        frame_start;

  modport master (
    output enable, value, dp_mask, load, dec_ss,
    input  dec_num, seg_n, an_n, pending, frame_start
  );

  modport slave (
    input  enable, value, dp_mask, load, dec_ss,
    output dec_num, seg_n, an_n, pending, frame_start
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed 7-segment scanner with inter-digit blanking and a frame-synchronous shadow register.
// Define SEVENSEG_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seven_seg_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                clk,
  input logic                rst,
  seven_seg_scanner_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    BLANK    = 2'd1,
    SHOW     = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       d_reg, d_next;
  logic [15:0]      active_val_reg, active_val_next;
  logic [3:0]       active_dp_reg, active_dp_next;
  logic [15:0]      shadow_val_reg, shadow_val_next;
  logic [3:0]       shadow_dp_reg, shadow_dp_next;
  logic             pending_reg, pending_next;
  logic [7:0]       seg_n_reg, seg_n_next;
  logic [3:0]       an_n_reg, an_n_next;
  logic             frame_start_reg, frame_start_next;
  logic             boundary;
  logic [3:0]       lz_blank;

`ifdef SEVENSEG_LZB_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lzb
      if (gi == 0) begin : g_digit0
        assign lz_blank[gi] = 1'b0;
      end else begin : g_digitn
        // A digit is leading only if it and every more significant nibble are zero.
        assign lz_blank[gi] = (active_val_reg[15:4*gi] == '0) && !active_dp_reg[gi];
      end
    end
  endgenerate
`else
  assign lz_blank = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= DISABLED;
      cnt_reg         <= '0;
      d_reg           <= 2'd0;
      active_val_reg  <= 16'h0000;
      active_dp_reg   <= 4'h0;
      shadow_val_reg  <= 16'h0000;
      shadow_dp_reg   <= 4'h0;
      pending_reg     <= 1'b0;
      seg_n_reg       <= 8'hFF;
      an_n_reg        <= 4'hF;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      d_reg           <= d_next;
      active_val_reg  <= active_val_next;
      active_dp_reg   <= active_dp_next;
      shadow_val_reg  <= shadow_val_next;
      shadow_dp_reg   <= shadow_dp_next;
      pending_reg     <= pending_next;
      seg_n_reg       <= seg_n_next;
      an_n_reg        <= an_n_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    d_next           = d_reg;
    active_val_next  = active_val_reg;
    active_dp_next   = active_dp_reg;
    shadow_val_next  = shadow_val_reg;
    shadow_dp_next   = shadow_dp_reg;
    pending_next     = pending_reg;
    an_n_next        = 4'hF;
    boundary         = bus.enable && (cnt_reg == '0) && (d_reg == 2'd0);

    if (!bus.enable) begin
      state_next = DISABLED;
      cnt_next   = '0;
      d_next     = 2'd0;
    end else begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        d_next   = d_reg + 2'd1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
      state_next = (cnt_next < CNT_BLANK) ? BLANK : SHOW;
    end

    // Swap reads the pre-load shadow, so a load in the boundary cycle waits a frame.
    if (boundary && pending_reg) begin
      active_val_next = shadow_val_reg;
      active_dp_next  = shadow_dp_reg;
      pending_next    = 1'b0;
    end
    if (bus.load) begin
      shadow_val_next = bus.value;
      shadow_dp_next  = bus.dp_mask;
      pending_next    = 1'b1;
    end

    frame_start_next = boundary;
    seg_n_next       = ~{bus.dec_ss[7:1], bus.dec_ss[0] | active_dp_reg[d_reg]};

    // A DISABLED state_reg with enable high is the restart cycle, which is blank.
    if (bus.enable && (state_reg == SHOW) && !lz_blank[d_reg]) begin
      an_n_next = ~(4'b0001 << d_reg);
    end
  end

  assign bus.dec_num     = active_val_reg[{d_reg, 2'b00} +: 4];
  assign bus.seg_n       = seg_n_reg;
  assign bus.an_n        = an_n_reg;
  assign bus.pending     = pending_reg;
  assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: each displayed frame's per-cycle anode/segment
// expectations are queued when the value is loaded and popped cycle by cycle from frame_start.
module tb_seven_seg_scanner;
  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 4 * CLK_DIV;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    bit         chk_seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   saw_nib1 = 1'b0;

  seven_seg_scanner_if bus();

  seven_seg_scanner #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference hex decoder, active-high {a,b,c,d,e,f,g,dp}
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hFC;  4'h1: hex7 = 8'h60;  4'h2: hex7 = 8'hDA;  4'h3: hex7 = 8'hF2;
      4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'hB6;  4'h6: hex7 = 8'hBE;  4'h7: hex7 = 8'hE0;
      4'h8: hex7 = 8'hFE;  4'h9: hex7 = 8'hF6;  4'hA: hex7 = 8'hEE;  4'hB: hex7 = 8'h3E;
      4'hC: hex7 = 8'h9C;  4'hD: hex7 = 8'h7A;  4'hE: hex7 = 8'h9E;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign bus.dec_ss = hex7(bus.dec_num);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
    for (int dg = 0; dg < 4; dg++) begin
      logic [7:0] p;
      bit         blank;
      p     = hex7(v[dg*4 +: 4]);
      p[0]  = p[0] | dp[dg];
      blank = 1'b0;
`ifdef SEVENSEG_LZB_EN
      if (dg > 0) begin
        blank = (dp[dg] == 1'b0);
        for (int k = dg; k < 4; k++) if (v[k*4 +: 4] != 4'h0) blank = 1'b0;
      end
`endif
      for (int c = 0; c < CLK_DIV; c++) begin
        exp_t e;
        e.an      = (c >= BLANK_CYCLES && !blank) ? ~(4'b0001 << dg) : 4'hF;
        e.seg     = ~p;
        e.chk_seg = (c >= 1);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input string name, input logic exp_pending);
    int n;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame_start !== 1'b1) begin
      check({name, "_frame_start_seen"}, 32'(bus.frame_start), 32'd1);
      sb_q.delete();
      return;
    end
    check({name, "_pending_at_frame"}, 32'(bus.pending), 32'(exp_pending));
    for (int i = 0; i < FRAME; i++) begin
      exp_t e;
      if (i > 0) begin
        @(negedge clk);
        check($sformatf("%s_frame_start[%0d]", name, i), 32'(bus.frame_start), 32'd0);
      end
      if (sb_q.size() == 0) break;
      e = sb_q.pop_front();
      if (bus.dec_num == 4'h1) saw_nib1 = 1'b1;
      check($sformatf("%s_an_n[%0d]", name, i), 32'(bus.an_n), 32'(e.an));
      if (e.chk_seg) check($sformatf("%s_seg_n[%0d]", name, i), 32'(bus.seg_n), 32'(e.seg));
    end
    $display("frame %s checked (%0d compared so far)", name, n_cmp);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value   = v;
    bus.dp_mask = dp;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
    bus.value   = 16'h0000;
    bus.dp_mask = 4'h0;
    $display("load value=%h dp=%b", v, dp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.enable  = 1'b1;
    bus.load    = 1'b0;
    bus.value   = 16'h0000;
    bus.dp_mask = 4'h0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an_n", 32'(bus.an_n), 32'h0000000F);
    check("rst_seg_n", 32'(bus.seg_n), 32'h000000FF);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    rst = 1'b0;

    push_frame(16'h0000, 4'h0);
    run_frame("after_reset", 1'b0);

    // Mid-frame load stays pending until the next boundary
    repeat (10) @(negedge clk);
    do_load(16'h12AF, 4'b0100);
    check("load_pending", 32'(bus.pending), 32'd1);
    repeat (5) @(negedge clk);
    check("still_pending", 32'(bus.pending), 32'd1);
    push_frame(16'h12AF, 4'b0100);
    run_frame("v12af", 1'b0);

    // Last of two loads in one frame wins
    repeat (4) @(negedge clk);
    do_load(16'h1111, 4'h0);
    do_load(16'h2222, 4'h0);
    check("double_load_pending", 32'(bus.pending), 32'd1);
    push_frame(16'h2222, 4'h0);
    saw_nib1 = 1'b0;
    run_frame("v2222", 1'b0);
    check("no_1111_shown", 32'(saw_nib1), 32'd0);

    // Load exactly in the boundary cycle: old value for one more frame
    do_load(16'h3456, 4'b0001);
    push_frame(16'h2222, 4'h0);
    run_frame("boundary_old", 1'b1);
    push_frame(16'h3456, 4'b0001);
    run_frame("boundary_new", 1'b0);

    // Disable during digit 2 SHOW, load while dark, then re-enable
    repeat (20) @(negedge clk);
    check("pre_disable_an_n", 32'(bus.an_n), 32'h0000000B);
    bus.enable = 1'b0;
    @(negedge clk);
    check("disable_an_n", 32'(bus.an_n), 32'h0000000F);
    do_load(16'hC0DE, 4'h0);
    repeat (3) @(negedge clk);
    check("disabled_an_n", 32'(bus.an_n), 32'h0000000F);
    check("disabled_frame_start", 32'(bus.frame_start), 32'd0);
    check("disabled_pending", 32'(bus.pending), 32'd1);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reenable_frame_start", 32'(bus.frame_start), 32'd1);
    push_frame(16'hC0DE, 4'h0);
    run_frame("reenable", 1'b0);

    // Leading zeros (blanked only when SEVENSEG_LZB_EN is defined)
    repeat (3) @(negedge clk);
    do_load(16'h0050, 4'h0);
    push_frame(16'h0050, 4'h0);
    run_frame("lzb_0050", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
